// File: rtl/systolic_pkg.sv
// Shared definitions for the weight-stationary systolic array.
//   state_t    : controller states (IDLE/LOAD/RUN/DRAIN, 2-bit encoding)
//   lat_of     : fixed accept-to-result latency, ROWS + COLS
//   prod_width : full-precision width of a DATA_WIDTH x DATA_WIDTH signed product;
//                the product is sign-extended (or wrapped) to ACC_WIDTH before
//                accumulation, so sums wrap modulo 2^ACC_WIDTH.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int unsigned lat_of(input int unsigned rows, input int unsigned cols);
    return rows + cols;
  endfunction

  function automatic int unsigned prod_width(input int unsigned dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element of the weight-stationary array.
//   clk, rst      : clock, asynchronous active-high reset
//   w_shift       : load the weight register from w_in (weights shift down a column)
//   w_in / w_out  : weight from the PE above / resident weight passed to the PE below
//   a_in / a_out  : activation from the left / registered copy for the PE to the right
//   v_in / v_out  : lane valid travelling with the activation
//   psum_in/out   : partial sum from above / registered psum_in + a_in*w for below
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_shift,
  input  logic signed [DATA_WIDTH-1:0] w_in,
  output logic signed [DATA_WIDTH-1:0] w_out,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic                         v_in,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic                         v_out,
  input  logic signed [ACC_WIDTH-1:0]  psum_in,
  output logic signed [ACC_WIDTH-1:0]  psum_out
);

  localparam int unsigned PW = prod_width(DATA_WIDTH);

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] term;

  assign prod = a_in * w_out;
  // Signed size cast sign-extends the product into the accumulator width.
  assign term = ACC_WIDTH'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_out    <= '0;
      a_out    <= '0;
      v_out    <= 1'b0;
      psum_out <= '0;
    end else begin
      if (w_shift) begin
        w_out <= w_in;
      end
      a_out    <= a_in;
      v_out    <= v_in;
      // An idle lane contributes a zero sum rather than stale data.
      psum_out <= v_in ? psum_in + term : '0;
    end
  end

endmodule

// File: rtl/systolic_array_ws.sv
// Weight-stationary ROWS x COLS systolic MAC array with built-in input skew,
// output deskew and weight-load shifting; clients present unskewed vectors.
//   array_clk, array_rst : clock, asynchronous active-high reset
//   w_valid/w_ready/w_data : weight row beats, last row first (ROWS-1 .. 0)
//   in_valid/in_ready/in_data : activation vector a[r] at [r*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_data : one-cycle result pulse, y[c] at [c*ACC_WIDTH +: ACC_WIDTH],
//                        ROWS+COLS cycles after acceptance; data holds between pulses
//   w_loaded : a complete weight set is resident
module systolic_array_ws
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                       array_clk,
  input  logic                       array_rst,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [COLS*DATA_WIDTH-1:0] w_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  output logic                       out_valid,
  output logic [COLS*ACC_WIDTH-1:0]  out_data,
  output logic                       w_loaded
);

  localparam int unsigned LAT = lat_of(ROWS, COLS);
  localparam int unsigned CW  = $clog2(ROWS + 1);

  state_t         state, state_nx;
  logic [CW-1:0]  load_cnt;
  logic [LAT-1:0] pend;
  logic           w_beat, in_beat, load_last;

  // Grid interconnect: weights/psums flow down, activations/valids flow right.
  logic signed [DATA_WIDTH-1:0] w_v  [ROWS+1][COLS];
  logic signed [ACC_WIDTH-1:0]  ps_v [ROWS+1][COLS];
  logic signed [DATA_WIDTH-1:0] a_h  [ROWS][COLS+1];
  logic                         v_h  [ROWS][COLS+1];
  logic [COLS*ACC_WIDTH-1:0]    dsk_out;

  // Outputs leaving the grid edge have no consumer.
  logic [ROWS-1:0] unused_east;
  logic [COLS-1:0] unused_south;

  assign w_beat    = w_valid & w_ready;
  assign in_beat   = in_valid & in_ready;
  assign load_last = (load_cnt == CW'(ROWS - 1));

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_nx = state;
    w_ready  = 1'b0;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        w_ready = 1'b1;
        if (w_valid) begin
          state_nx = load_last ? RUN : LOAD;
        end else if (w_loaded) begin
          state_nx = RUN;
        end
      end
      LOAD: begin
        w_ready = 1'b1;
        if (w_valid && load_last) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        // A weight request blocks the vector in the same cycle.
        in_ready = ~w_valid;
        if (w_valid) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (pend == '0) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (array_rst) begin
      w_ready  = 1'b0;
      in_ready = 1'b0;
    end
  end

  always_ff @(posedge array_clk or posedge array_rst) begin
    if (array_rst) begin
      state     <= IDLE;
      load_cnt  <= '0;
      w_loaded  <= 1'b0;
      pend      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nx;
      if (w_beat) begin
        if (load_last) begin
          load_cnt <= '0;
          w_loaded <= 1'b1;
        end else begin
          load_cnt <= load_cnt + 1'b1;
          w_loaded <= 1'b0;
        end
      end
      pend      <= {pend[LAT-2:0], in_beat};
      out_valid <= pend[LAT-1];
      if (pend[LAT-1]) begin
        out_data <= dsk_out;
      end
    end
  end

  // ---------------------------------------------------------------- input skew
  // Row r passes through r+1 registers, so PE(r,0) sees it r cycles after PE(0,0).
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic signed [DATA_WIDTH-1:0] sk_a [0:r];
    logic                         sk_v [0:r];

    always_ff @(posedge array_clk or posedge array_rst) begin
      if (array_rst) begin
        for (int unsigned k = 0; k <= r; k++) begin
          sk_a[k] <= '0;
          sk_v[k] <= 1'b0;
        end
      end else begin
        sk_a[0] <= in_data[r*DATA_WIDTH +: DATA_WIDTH];
        sk_v[0] <= in_beat;
        for (int unsigned k = 1; k <= r; k++) begin
          sk_a[k] <= sk_a[k-1];
          sk_v[k] <= sk_v[k-1];
        end
      end
    end

    assign a_h[r][0]      = sk_a[r];
    assign v_h[r][0]      = sk_v[r];
    assign unused_east[r] = ^{a_h[r][COLS], v_h[r][COLS]};
  end

  // ---------------------------------------------------------------- PE grid
  for (genvar c = 0; c < COLS; c++) begin : g_top
    assign w_v[0][c]       = w_data[c*DATA_WIDTH +: DATA_WIDTH];
    assign ps_v[0][c]      = '0;
    assign unused_south[c] = ^w_v[ROWS][c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      systolic_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk     (array_clk),
        .rst     (array_rst),
        .w_shift (w_beat),
        .w_in    (w_v[r][c]),
        .w_out   (w_v[r+1][c]),
        .a_in    (a_h[r][c]),
        .v_in    (v_h[r][c]),
        .a_out   (a_h[r][c+1]),
        .v_out   (v_h[r][c+1]),
        .psum_in (ps_v[r][c]),
        .psum_out(ps_v[r+1][c])
      );
    end
  end

  // ---------------------------------------------------------------- output deskew
  // Column c finishes c cycles after column 0; delaying it COLS-1-c cycles
  // aligns every column one cycle before the out_data register.
  for (genvar c = 0; c < COLS; c++) begin : g_dsk
    localparam int unsigned D = COLS - 1 - c;
    if (D == 0) begin : g_direct
      assign dsk_out[c*ACC_WIDTH +: ACC_WIDTH] = ps_v[ROWS][c];
    end else begin : g_delay
      logic signed [ACC_WIDTH-1:0] dq [D];

      always_ff @(posedge array_clk or posedge array_rst) begin
        if (array_rst) begin
          for (int unsigned k = 0; k < D; k++) begin
            dq[k] <= '0;
          end
        end else begin
          dq[0] <= ps_v[ROWS][c];
          for (int unsigned k = 1; k < D; k++) begin
            dq[k] <= dq[k-1];
          end
        end
      end

      assign dsk_out[c*ACC_WIDTH +: ACC_WIDTH] = dq[D-1];
    end
  end

endmodule

// File: tb/tb_systolic_array_ws.sv
`timescale 1ns/1ps
module tb_systolic_array_ws;

  localparam int R   = 4;
  localparam int C   = 4;
  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int AW2 = 16;

  typedef logic [3:0][7:0]  vec8_t;
  typedef logic [3:0][31:0] vec32_t;
  typedef struct packed {
    vec8_t  a;
    vec32_t y;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main 4x4, 32-bit accumulator instance
  logic              w_valid = 1'b0;
  logic              w_ready;
  logic [C*DW-1:0]   w_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [R*DW-1:0]   in_data = '0;
  logic              out_valid;
  logic [C*AW-1:0]   out_data;
  logic              w_loaded;

  // 16-bit accumulator instance for the wrap case
  logic              wv2 = 1'b0;
  logic              wr2;
  logic [C*DW-1:0]   wd2 = '0;
  logic              iv2 = 1'b0;
  logic              ir2;
  logic [R*DW-1:0]   id2 = '0;
  logic              ov2;
  logic [C*AW2-1:0]  od2;
  logic              wl2;

  systolic_array_ws #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .array_clk(clk), .array_rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .w_loaded(w_loaded)
  );

  systolic_array_ws #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW2)) dut_w (
    .array_clk(clk), .array_rst(rst),
    .w_valid(wv2), .w_ready(wr2), .w_data(wd2),
    .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_data(od2), .w_loaded(wl2)
  );

  int            n_pass  = 0;
  int            n_total = 0;
  int            pulses  = 0;
  logic [C*AW-1:0] last_out = '0;
  vec_t          tbl [3];

  always @(negedge clk) begin
    if (out_valid) begin
      pulses++;
      last_out = out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic vec8_t pk8(input int v0, input int v1, input int v2, input int v3);
    vec8_t v;
    v[0] = 8'(v0); v[1] = 8'(v1); v[2] = 8'(v2); v[3] = 8'(v3);
    return v;
  endfunction

  function automatic vec32_t pk32(input int v0, input int v1, input int v2, input int v3);
    vec32_t v;
    v[0] = 32'(v0); v[1] = 32'(v1); v[2] = 32'(v2); v[3] = 32'(v3);
    return v;
  endfunction

  // Stimulus weights: reference W[r][c] = 4r+c+1, or identity.
  function automatic logic [7:0] wt(input int r, input int c, input bit ident);
    if (ident) return (r == c) ? 8'd1 : 8'd0;
    return 8'(4 * r + c + 1);
  endfunction

  function automatic longint ycol(input int c);
    return longint'($signed(out_data[c*AW +: AW]));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic check_y(input string tag, input vec32_t e);
    for (int c = 0; c < C; c++)
      check($sformatf("%s_y%0d", tag, c), ycol(c), longint'($signed(e[c])));
  endtask

  task automatic load_w(input bit ident);
    int g;
    for (int r = R - 1; r >= 0; r--) begin
      for (int c = 0; c < C; c++) w_data[c*DW +: DW] = wt(r, c, ident);
      w_valid = 1'b1;
      #1;
      g = 0;
      while (!w_ready && g < 40) begin tick(); g++; end
      check($sformatf("load_row%0d_w_ready", r), w_ready, 1);
      check($sformatf("load_row%0d_in_ready", r), in_ready, 0);
      if (r != R - 1) check($sformatf("load_row%0d_w_loaded", r), w_loaded, 0);
      tick();
    end
    w_valid = 1'b0;
    #1;
    check("load_done_w_loaded", w_loaded, 1);
    check("load_done_in_ready", in_ready, 1);
  endtask

  task automatic send_vec(input vec8_t a);
    int g;
    in_data  = a;
    in_valid = 1'b1;
    #1;
    g = 0;
    while (!in_ready && g < 40) begin tick(); g++; end
    check("send_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin tick(); cycles++; end
    check("wait_out_valid", out_valid, 1);
  endtask

  initial begin : main
    int g, lat, got_n, first_k, last_k, p0, bad;
    logic [C*AW-1:0] got [3];

    tbl[0].a = pk8(1, 4, 7, 10);  tbl[0].y = pk32(214, 236, 258, 280);
    tbl[1].a = pk8(2, 5, 8, 11);  tbl[1].y = pk32(242, 268, 294, 320);
    tbl[2].a = pk8(3, 6, 9, 12);  tbl[2].y = pk32(270, 300, 330, 360);
    for (int i = 0; i < 3; i++) got[i] = '0;

    // 1: reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_w_ready", w_ready, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_w_loaded", w_loaded, 0);
    check("rst_out_data_zero", (out_data == '0), 1);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("idle_flags%0d", k),
            {out_valid, w_loaded, w_ready, in_ready, (out_data != '0)}, 5'b00100);
    end

    // 5: accumulator wrap on the 16-bit instance
    wd2 = pk8(127, 127, 127, 127);
    wv2 = 1'b1;
    for (int r = 0; r < R; r++) begin
      #1;
      check($sformatf("wrap_w_ready%0d", r), wr2, 1);
      tick();
    end
    wv2 = 1'b0;
    #1;
    check("wrap_w_loaded", wl2, 1);
    id2 = pk8(127, 127, 127, 127);
    iv2 = 1'b1;
    #1;
    check("wrap_in_ready", ir2, 1);
    tick();
    iv2 = 1'b0;
    g = 0;
    while (!ov2 && g < 40) begin tick(); g++; end
    check("wrap_out_valid", ov2, 1);
    for (int c = 0; c < C; c++)
      check($sformatf("wrap_y%0d", c), longint'($signed(od2[c*AW2 +: AW2])), -1020);

    // 2: single vector, exact latency
    load_w(1'b0);
    send_vec(pk8(1, 4, 7, 10));
    wait_out(lat);
    check("latency", lat, R + C);
    check_y("single", pk32(214, 236, 258, 280));
    tick();
    check("pulse_width", out_valid, 0);
    check("hold_y3", ycol(3), 280);

    // 3: back-to-back vectors from the table
    for (int i = 0; i < 3; i++) begin
      in_data  = tbl[i].a;
      in_valid = 1'b1;
      #1;
      check($sformatf("b2b_in_ready%0d", i), in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    got_n = 0; first_k = -1; last_k = -1;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        if (got_n < 3) got[got_n] = out_data;
        if (first_k < 0) first_k = k;
        last_k = k;
        got_n++;
      end
      tick();
    end
    check("b2b_pulses", got_n, 3);
    check("b2b_consecutive", last_k - first_k, 2);
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < C; c++)
        check($sformatf("b2b_v%0d_y%0d", i, c),
              longint'($signed(got[i][c*AW +: AW])), longint'($signed(tbl[i].y[c])));

    // 4: weight reload one cycle after a vector is accepted
    p0 = pulses;
    send_vec(pk8(1, 4, 7, 10));
    for (int c = 0; c < C; c++) w_data[c*DW +: DW] = wt(R - 1, c, 1'b1);
    w_valid = 1'b1;
    #1;
    check("reload_in_ready_drop", in_ready, 0);
    load_w(1'b1);
    check("reload_pending_pulse", pulses - p0, 1);
    for (int c = 0; c < C; c++)
      check($sformatf("reload_pending_y%0d", c), longint'($signed(last_out[c*AW +: AW])),
            longint'($signed(tbl[0].y[c])));
    send_vec(pk8(-3, 5, -7, 9));
    wait_out(lat);
    check_y("ident", pk32(-3, 5, -7, 9));

    // 6: reset with two vectors in flight
    send_vec(pk8(1, 1, 1, 1));
    send_vec(pk8(2, 2, 2, 2));
    tick();
    p0 = pulses;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_w_loaded", w_loaded, 0);
    check("midrst_in_ready", in_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (in_ready || out_valid || w_loaded) bad++;
    end
    check("postrst_quiet_cycles", bad, 0);
    check("postrst_no_pulse", pulses - p0, 0);
    check("postrst_w_ready", w_ready, 1);
    load_w(1'b0);
    send_vec(pk8(2, 5, 8, 11));
    wait_out(lat);
    check_y("recover", pk32(242, 268, 294, 320));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
